// File: rtl/ps2_mouse_init_ctrl.sv
// rtl/ps2_mouse_init_ctrl.sv - PS/2 mouse power-up/config sequencer feeding the packet reader enable
// Define PS2_MOUSE_EXT_EN to include the IntelliMouse rate knock and ID probe (steps 1-7).
module ps2_mouse_init_ctrl #(
  parameter logic [23:0] TIMEOUT     = 24'd10_000_000,
  parameter logic [24:0] BAT_TIMEOUT = 25'd30_000_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       iRestart,
  output logic       oWrReq,
  output logic [7:0] oWrData,
  input  logic       iWrDone,
  input  logic       iRxTrig,
  input  logic [7:0] iRxData,
  output logic [1:0] oEn,
  output logic       oReady,
  output logic       oError
);

  typedef enum logic [2:0] {
    S_SEND, S_WAIT_ACK, S_WAIT_BAT, S_WAIT_ID0, S_WAIT_ID, S_NEXT, S_DONE, S_ERR
  } state_t;

  localparam logic [7:0] LP_MAX_RETRY = 8'(MAX_RETRY);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_step, w_step_nxt;
  logic [7:0]  r_retry, w_retry_nxt;
  logic [24:0] r_timer, w_timer_nxt;
  logic        r_wr_req, w_wr_req_nxt;
  logic [7:0]  r_wr_data, w_wr_data_nxt;
  logic        r_ext, w_ext_nxt;
  logic [24:0] w_limit;
  logic        w_timeout;
  logic        w_resend;
  logic        w_restart;

  function automatic logic [7:0] cmd_byte(input logic [3:0] step);
    case (step)
      4'd0:    cmd_byte = 8'hFF;
      4'd1:    cmd_byte = 8'hF3;
      4'd2:    cmd_byte = 8'hC8;
      4'd3:    cmd_byte = 8'hF3;
      4'd4:    cmd_byte = 8'h64;
      4'd5:    cmd_byte = 8'hF3;
      4'd6:    cmd_byte = 8'h50;
      4'd7:    cmd_byte = 8'hF2;
      default: cmd_byte = 8'hF4;
    endcase
  endfunction

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state   <= S_SEND;
      r_step    <= '0;
      r_retry   <= '0;
      r_timer   <= '0;
      r_wr_req  <= 1'b0;
      r_wr_data <= 8'h00;
      r_ext     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_retry   <= w_retry_nxt;
      r_timer   <= w_timer_nxt;
      r_wr_req  <= w_wr_req_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_ext     <= w_ext_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_step_nxt    = r_step;
    w_retry_nxt   = r_retry;
    w_timer_nxt   = r_timer;
    w_wr_req_nxt  = r_wr_req;
    w_wr_data_nxt = r_wr_data;
    w_ext_nxt     = r_ext;
    w_resend      = 1'b0;
    w_restart     = 1'b0;
    // The self-test result (AAh/00h) after reset is much slower than a plain ACK.
    w_limit   = (r_state == S_WAIT_BAT || r_state == S_WAIT_ID0) ? BAT_TIMEOUT : {1'b0, TIMEOUT};
    w_timeout = ({1'b0, r_timer} + 26'd1) >= {1'b0, w_limit};

    case (r_state)
      S_SEND: begin
        if (!r_wr_req) begin
          w_wr_req_nxt  = 1'b1;
          w_wr_data_nxt = cmd_byte(r_step);
        end else if (iWrDone) begin
          w_wr_req_nxt = 1'b0;
          w_timer_nxt  = '0;
          w_state_nxt  = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        w_timer_nxt = r_timer + 25'd1;
        if (iRxTrig) begin
          w_timer_nxt = '0;
          if (iRxData == 8'hFA) begin
            if (r_step == 4'd0)      w_state_nxt = S_WAIT_BAT;
            else if (r_step == 4'd7) w_state_nxt = S_WAIT_ID;
            else                     w_state_nxt = S_NEXT;
          end else if (iRxData == 8'hFE) begin
            w_resend = 1'b1;
          end else begin
            w_restart = 1'b1;
          end
        end else if (w_timeout) begin
          w_restart = 1'b1;
        end
      end
      S_WAIT_BAT, S_WAIT_ID0: begin
        w_timer_nxt = r_timer + 25'd1;
        if (iRxTrig) begin
          w_timer_nxt = '0;
          if (r_state == S_WAIT_BAT && iRxData == 8'hAA)      w_state_nxt = S_WAIT_ID0;
          else if (r_state == S_WAIT_ID0 && iRxData == 8'h00) w_state_nxt = S_NEXT;
          else                                                w_restart = 1'b1;
        end else if (w_timeout) begin
          w_restart = 1'b1;
        end
      end
      S_WAIT_ID: begin
        w_timer_nxt = r_timer + 25'd1;
        if (iRxTrig) begin
          w_timer_nxt = '0;
`ifdef PS2_MOUSE_EXT_EN
          w_ext_nxt   = (iRxData == 8'h03);
`endif
          w_state_nxt = S_NEXT;
        end else if (w_timeout) begin
          w_restart = 1'b1;
        end
      end
      S_NEXT: begin
        if (r_step == 4'd8) begin
          w_state_nxt = S_DONE;
        end else begin
`ifdef PS2_MOUSE_EXT_EN
          w_step_nxt = r_step + 4'd1;
`else
          w_step_nxt = 4'd8;
`endif
          w_state_nxt = S_SEND;
        end
      end
      S_DONE: w_retry_nxt = '0;
      default: ;
    endcase

    if (w_resend || w_restart) begin
      w_timer_nxt = '0;
      if (r_retry + 8'd1 == LP_MAX_RETRY) begin
        w_state_nxt = S_ERR;
      end else begin
        w_state_nxt = S_SEND;
        w_retry_nxt = r_retry + 8'd1;
        if (w_restart) w_step_nxt = '0;
      end
    end

    // Dropping the request here guarantees the writer sees it low before the FFh request.
    if (iRestart) begin
      w_state_nxt  = S_SEND;
      w_step_nxt   = '0;
      w_retry_nxt  = '0;
      w_timer_nxt  = '0;
      w_wr_req_nxt = 1'b0;
      w_ext_nxt    = 1'b0;
    end
  end

  assign oWrReq  = r_wr_req;
  assign oWrData = r_wr_data;
  assign oEn     = (r_state == S_DONE) ? (r_ext ? 2'b10 : 2'b01) : 2'b00;
  assign oReady  = (r_state == S_DONE);
  assign oError  = (r_state == S_ERR);

endmodule
